regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL expose parameter NREGS, default 16, meaning number of architectural registers tracked; values other than 16 are not supported.
REQ-002 SHALL expose parameter CNTW, default 2, meaning the width of each per-register pending counter, giving a maximum of 3 in-flight writes per register.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports issue_valid, input, 1 bit: decode presents an instruction this cycle.
REQ-006 SHALL have port issue_ready, output, 1 bit: the scoreboard accepts the instruction; issue fires when issue_valid && issue_ready.
REQ-007 SHALL have ports src_a_valid and src_b_valid, input, 1 bit each, and src_a and src_b, input, [0:3] each: source register indices.
REQ-008 SHALL have ports dst_valid, input, 1 bit, and dst, input, [0:3]: primary destination register.
REQ-009 SHALL have ports dst2_valid, input, 1 bit, and dst2, input, [0:3]: second destination (MUL/DIV writing rax and rdx).
REQ-010 SHALL have port dst_rsp, input, 1 bit: implicit rsp (reg 4) write for push/pop/call/ret.
REQ-011 SHALL have ports wb_valid, input, 1 bit, and wb_mask, input, [0:15]: registers written by writeback this cycle, where bit i is register i.
REQ-012 SHALL have port drain_req, input, 1 bit: request to quiesce the pipeline (syscall, sim_end).
REQ-013 SHALL have port drain_done, output, 1 bit: single-cycle pulse when the drain completes.
REQ-014 SHALL have port flush, input, 1 bit: synchronously discard all pending state.
REQ-015 SHALL have port busy_mask, output, [0:15]: bit i is high when counter i is non-zero.
REQ-016 SHALL have port stall, output, 1 bit: equal to issue_valid && !issue_ready.
REQ-017 SHALL have port sb_error, output, 1 bit: sticky flag set on a release to an idle register.

Function
REQ-018 SHALL form the issue destination mask as the OR of dst (if dst_valid), dst2 (if dst2_valid) and reg 4 (if dst_rsp); a register is counted at most once per issue.
REQ-019 SHALL drive issue_ready from registered state only: state RUN, no valid source with a non-zero counter, and no mask destination with a counter at 3.
REQ-020 SHALL NOT let a same-cycle writeback make issue_ready high (no bypass).
REQ-021 SHALL, on each clock, change each counter by +1 if the register is in the fired issue mask, -1 if it is in wb_mask while wb_valid, and net 0 when both apply.
REQ-022 SHALL, on a release to a counter at 0, leave the counter at 0 and set sb_error until reset.
REQ-023 SHALL implement FSM states RUN and DRAIN.
REQ-024 SHALL transition RUN->DRAIN when drain_req is high; issue_ready is 0 in DRAIN.
REQ-025 SHALL, in DRAIN when all counters are zero, pulse drain_done for one cycle and return to RUN on the next edge.
REQ-026 SHALL, when DRAIN is entered with all counters already zero, pulse drain_done on the following cycle.
REQ-027 SHALL, on flush, zero all counters and return the FSM to RUN on the next edge; flush has priority over issue, writeback and drain, any fired issue that cycle is dropped, and drain_done is not pulsed.
REQ-028 SHALL let drain_req held high across the return to RUN start a new drain.

Reset
REQ-029 SHALL, while reset is high, immediately force: all counters to 0, FSM to RUN, busy_mask to 0, drain_done to 0, sb_error to 0; issue_ready follows as 1 and stall as 0.
REQ-030 SHALL, on reset asserted mid-operation, discard all in-flight state with no writeback accounting required afterward.

Verification
REQ-031 SHALL cover: issue dst=3, then issue src_a=3 -> stall=1 until wb_mask bit 3 is seen, issue_ready=1 the cycle after.
REQ-032 SHALL cover: three issues to dst=0 with no writeback -> counter 0 reaches 3, the fourth issue to dst=0 stalls, one wb on reg 0 unblocks it.
REQ-033 SHALL cover: MUL issue dst=0, dst2=2 -> busy_mask bits 0 and 2 set; wb_mask with bits 0 and 2 set clears both in one cycle.
REQ-034 SHALL cover: push (dst_rsp=1, dst=4) -> reg 4 counter is 1, not 2; simultaneous issue and wb on reg 4 leaves it at 1.
REQ-035 SHALL cover: drain_req with regs 1 and 5 pending -> issue_ready=0; drain_done pulses exactly once, one cycle after the last wb.
REQ-036 SHALL cover: wb on idle reg 7 -> sb_error=1 sticky; flush during DRAIN -> counters 0, RUN, no drain_done; async reset mid-stream -> outputs at reset values without a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register scoreboard: per-register in-flight write counters gate instruction issue,
// with a RUN/DRAIN controller for pipeline quiesce and a sticky release-underflow flag.

module sb_cnt #(
   parameter int CNTW = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic flush_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic busy_o,
   output logic full_o,
   output logic uflow_o
);
   localparam logic [CNTW-1:0] MAX = '1;

   logic [CNTW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i)
         cnt_d = '0;
      else if (inc_i && !dec_i && cnt_q != MAX)
         cnt_d = cnt_q + CNTW'(1);
      else if (dec_i && !inc_i && cnt_q != '0)
         cnt_d = cnt_q - CNTW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign busy_o  = (cnt_q != '0);
   assign full_o  = (cnt_q == MAX);
   // A release matched by a same-cycle issue nets to zero and is not an underflow.
   assign uflow_o = !flush_i && dec_i && !inc_i && (cnt_q == '0);
endmodule

module regfile_scoreboard #(
   parameter int NREGS = 16,
   parameter int CNTW  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic             src_a_valid,
   input  logic             src_b_valid,
   input  logic [0:3]       src_a,
   input  logic [0:3]       src_b,
   input  logic             dst_valid,
   input  logic [0:3]       dst,
   input  logic             dst2_valid,
   input  logic [0:3]       dst2,
   input  logic             dst_rsp,
   input  logic             wb_valid,
   input  logic [0:NREGS-1] wb_mask,
   input  logic             drain_req,
   output logic             drain_done,
   input  logic             flush,
   output logic [0:NREGS-1] busy_mask,
   output logic             stall,
   output logic             sb_error
);
   localparam int RSP = 4;

   typedef enum logic {RUN, DRAIN} state_e;

   state_e           state_q, state_d;
   logic [NREGS-1:0] iss_mask, inc, dec, busy, full, uflow;
   logic             hazard, fire, all_idle;
   logic             sb_error_q, sb_error_d;

   // Destinations are OR-ed so a register named twice still counts once.
   always_comb begin
      iss_mask = '0;
      if (dst_valid)  iss_mask[dst]  = 1'b1;
      if (dst2_valid) iss_mask[dst2] = 1'b1;
      if (dst_rsp)    iss_mask[RSP]  = 1'b1;
   end

   // Ready looks only at registered counters: a same-cycle writeback never bypasses.
   assign hazard      = (src_a_valid && busy[src_a]) || (src_b_valid && busy[src_b]) ||
                        (|(iss_mask & full));
   assign issue_ready = (state_q == RUN) && !hazard;
   assign stall       = issue_valid && !issue_ready;
   assign fire        = issue_valid && issue_ready && !flush;
   assign all_idle    = ~|busy;

   for (genvar g = 0; g < NREGS; g++) begin : g_reg
      assign inc[g]       = fire && iss_mask[g];
      assign dec[g]       = wb_valid && wb_mask[g];
      assign busy_mask[g] = busy[g];

      sb_cnt #(.CNTW(CNTW)) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .flush_i (flush),
         .inc_i   (inc[g]),
         .dec_i   (dec[g]),
         .busy_o  (busy[g]),
         .full_o  (full[g]),
         .uflow_o (uflow[g])
      );
   end

   always_comb begin
      state_d    = state_q;
      drain_done = 1'b0;
      case (state_q)
         RUN:   if (drain_req) state_d = DRAIN;
         DRAIN: if (all_idle) begin
            drain_done = 1'b1;
            state_d    = RUN;
         end
         default: state_d = RUN;
      endcase
      if (flush) begin
         state_d    = RUN;
         drain_done = 1'b0;
      end
   end

   assign sb_error_d = sb_error_q || (|uflow);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         sb_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sb_error_q <= sb_error_d;
      end
   end

   assign sb_error = sb_error_q;
endmodule
